// File: rtl/dense_pkg.sv
// dense_pkg: shared state encoding, widths and defaults for the dense-layer sequencer.
package dense_pkg;

   localparam int N_FEATURES_DEF = 169;
   localparam int FEAT_W         = 16;
   localparam int SCORE_W        = 32;
   localparam int ADDR_W         = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_STREAM    = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_RESULT    = 3'd4
   } seq_state_e;

   typedef logic signed [FEAT_W-1:0]  feature_t;
   typedef logic signed [SCORE_W-1:0] score_t;

endpackage

// File: rtl/dense_sequencer_if.sv
// dense_sequencer_if: start/result handshake, feature-buffer read port and dense-layer link.
interface dense_sequencer_if;
   import dense_pkg::*;

   logic              start_req;
   logic              busy;
   logic              fb_rd_en;
   logic [ADDR_W-1:0] fb_addr;
   feature_t          fb_rdata;
   logic              dl_start;
   feature_t          dl_feature;
   logic              dl_done;
   score_t            dl_score0;
   score_t            dl_score1;
   logic              result_valid;
   logic              result_ready;
   logic              result_class;
   score_t            result_score;
   logic              timeout_err;

   modport master (
      input  start_req, fb_rdata, dl_done, dl_score0, dl_score1, result_ready,
      output busy, fb_rd_en, fb_addr, dl_start, dl_feature,
             result_valid, result_class, result_score, timeout_err
   );

   modport slave (
      output start_req, fb_rdata, dl_done, dl_score0, dl_score1, result_ready,
      input  busy, fb_rd_en, fb_addr, dl_start, dl_feature,
             result_valid, result_class, result_score, timeout_err
   );

endinterface

// File: rtl/dense_argmax.sv
// dense_argmax: signed two-way argmax; a tie resolves to class 0.
module dense_argmax
   import dense_pkg::*;
(
   input  score_t score0,
   input  score_t score1,
   output logic   win_class,
   output score_t win_score
);

   always_comb begin
      win_class = 1'b0;
      win_score = score0;
      if (score1 > score0) begin
         win_class = 1'b1;
         win_score = score1;
      end
   end

endmodule

// File: rtl/dense_sequencer.sv
// dense_sequencer: streams N_FEATURES buffer words into the dense layer and reports the argmax class.
// Defining DENSE_SEQ_TIMEOUT_EN adds a dl_done watchdog driving the sticky timeout_err flag.
module dense_sequencer
   import dense_pkg::*;
#(
   parameter int N_FEATURES   = N_FEATURES_DEF,
   parameter int DONE_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   dense_sequencer_if.master bus
);

   localparam int CNT_W = $clog2(N_FEATURES + 1);

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             result_class_q, result_class_d;
   score_t           result_score_q, result_score_d;
   logic             win_class;
   score_t           win_score;
   logic             wait_expired;

   dense_argmax u_argmax (
      .score0    (bus.dl_score0),
      .score1    (bus.dl_score1),
      .win_class (win_class),
      .win_score (win_score)
   );

`ifdef DENSE_SEQ_TIMEOUT_EN
   localparam int WAIT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_err_q, timeout_err_d;

   // Counts WAIT_DONE cycles; expiry lands exactly DONE_TIMEOUT cycles after entry.
   assign wait_expired    = (wait_cnt_q == WAIT_W'(DONE_TIMEOUT - 1));
   assign bus.timeout_err = timeout_err_q;

   always_comb begin
      wait_cnt_d    = '0;
      timeout_err_d = timeout_err_q;
      if ((state_q == ST_WAIT_DONE) && !bus.dl_done) begin
         if (wait_expired) begin
            timeout_err_d = 1'b1;
         end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end
`else
   assign wait_expired    = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   // fb_rdata already comes from the buffer's read register, so it is forwarded during STREAM only.
   always_comb begin
      state_d          = state_q;
      cnt_d            = '0;
      result_class_d   = result_class_q;
      result_score_d   = result_score_q;
      bus.busy         = (state_q != ST_IDLE);
      bus.fb_rd_en     = 1'b0;
      bus.fb_addr      = '0;
      bus.dl_start     = 1'b0;
      bus.dl_feature   = '0;
      bus.result_valid = 1'b0;
      bus.result_class = 1'b0;
      bus.result_score = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start_req) begin
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            bus.dl_start = 1'b1;
            bus.fb_rd_en = 1'b1;
            cnt_d        = CNT_W'(1);
            state_d      = ST_STREAM;
         end
         ST_STREAM: begin
            bus.dl_feature = bus.fb_rdata;
            if (cnt_q < CNT_W'(N_FEATURES)) begin
               bus.fb_rd_en = 1'b1;
               bus.fb_addr  = ADDR_W'(cnt_q);
            end
            if (cnt_q == CNT_W'(N_FEATURES)) begin
               state_d = ST_WAIT_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (bus.dl_done) begin
               result_class_d = win_class;
               result_score_d = win_score;
               state_d        = ST_RESULT;
            end else if (wait_expired) begin
               result_class_d = 1'b0;
               result_score_d = '0;
               state_d        = ST_RESULT;
            end
         end
         ST_RESULT: begin
            bus.result_valid = 1'b1;
            bus.result_class = result_class_q;
            bus.result_score = result_score_q;
            if (bus.result_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         result_class_q <= 1'b0;
         result_score_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         result_class_q <= result_class_d;
         result_score_q <= result_score_d;
      end
   end

endmodule

// File: tb/tb_dense_sequencer.sv
// tb_dense_sequencer: directed checks against a behavioural feature buffer and dense_layer model.
// Define DENSE_SEQ_TIMEOUT_EN in both RTL and bench builds to exercise the dl_done watchdog.
module tb_dense_sequencer;
   import dense_pkg::*;

   localparam int N        = 169;
   localparam int TMO      = 16;
   localparam int MAX_WAIT = 600;

   logic clk;
   logic reset_n;
   int   tests_run;
   int   tests_failed;

   logic signed [FEAT_W-1:0] mem [0:255];
   int   rec [0:N-1];
   int   w0, w1, b0, b1;
   bit   hold_done_low;
   bit   dl_active;
   int   dl_cnt;
   int   dl_pend;
   int   acc;

   dense_sequencer_if bus ();

   dense_sequencer #(.N_FEATURES(N), .DONE_TIMEOUT(TMO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin : feature_buffer
      if (bus.fb_rd_en) bus.fb_rdata <= mem[bus.fb_addr];
   end

   // dense_layer: accumulates the stream, raises dl_done a few cycles after the last feature.
   // A done level from the previous run lingers into the next STREAM to prove it is ignored.
   always @(posedge clk or negedge reset_n) begin : dense_layer
      if (!reset_n) begin
         dl_active     <= 1'b0;
         dl_cnt        <= 0;
         dl_pend       <= 0;
         acc           <= 0;
         bus.dl_done   <= 1'b0;
         bus.dl_score0 <= '0;
         bus.dl_score1 <= '0;
      end else if (bus.dl_start) begin
         dl_active <= 1'b1;
         dl_cnt    <= 0;
         dl_pend   <= 0;
         acc       <= 0;
      end else if (dl_active) begin
         rec[dl_cnt] <= int'(bus.dl_feature);
         acc         <= acc + int'(bus.dl_feature);
         dl_cnt      <= dl_cnt + 1;
         if (dl_cnt == 1) bus.dl_done <= 1'b0;
         if (dl_cnt == N - 1) begin
            dl_active <= 1'b0;
            dl_pend   <= 3;
         end
      end else if (dl_pend != 0) begin
         dl_pend <= dl_pend - 1;
         if ((dl_pend == 1) && !hold_done_low) begin
            bus.dl_done   <= 1'b1;
            bus.dl_score0 <= w0 * acc + b0;
            bus.dl_score1 <= w1 * acc + b1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int pattern, input int iw0, input int iw1, input int ib0, input int ib1);
      for (int k = 0; k < 256; k++) mem[k] = (pattern == 0) ? 16'sd1 : 16'(k);
      w0 = iw0;
      w1 = iw1;
      b0 = ib0;
      b1 = ib1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput(tag, 64'({2'b00, bus.busy, bus.fb_rd_en, bus.fb_addr, bus.dl_start, bus.dl_feature,
                            bus.result_valid, bus.result_class, bus.result_score, bus.timeout_err}), 64'd0);
   endtask

   task automatic launchRun(input string tag);
      bus.start_req = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_launch"}, 64'({bus.busy, bus.dl_start, bus.fb_rd_en, bus.fb_addr}),
                  64'({1'b1, 1'b1, 1'b1, 8'd0}));
      bus.start_req = 1'b0;
   endtask

   task automatic waitRun(input string tag, output int cyc);
      cyc = -1;
      for (int i = 1; i <= MAX_WAIT; i++) begin
         @(negedge clk);
         if (i == 1)
            checkOutput({tag, "_first_addr"}, 64'({bus.fb_rd_en, bus.fb_addr}), 64'({1'b1, 8'd1}));
         if (i == N + 1)
            checkOutput({tag, "_wait_bus"}, 64'({bus.busy, bus.fb_rd_en, bus.fb_addr, bus.dl_feature}),
                        64'({1'b1, 1'b0, 8'd0, 16'd0}));
         if (bus.result_valid) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic checkResult(input string tag, input int cyc, input int exp_cyc, input int exp_class, input int exp_score);
      checkOutput({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
      checkOutput({tag, "_class"}, 64'(bus.result_class), 64'(exp_class));
      checkOutput({tag, "_score"}, 64'(bus.result_score), 64'(exp_score));
   endtask

   task automatic acceptResult(input string tag);
      bus.result_ready = 1'b1;
      @(negedge clk);
      bus.result_ready = 1'b0;
      checkOutput({tag, "_released"}, 64'({bus.busy, bus.result_valid}), 64'd0);
   endtask

   initial begin
      int cyc;
      tests_run        = 0;
      tests_failed     = 0;
      reset_n          = 1'b0;
      hold_done_low    = 1'b0;
      bus.start_req    = 1'b0;
      bus.result_ready = 1'b0;

      applyStimulus(0, 1, 2, 50, 100);
      repeat (3) @(negedge clk);
      checkAllZero("reset_outputs");
      reset_n = 1'b1;

      // All-ones buffer: 169+50=219 vs 338+100=438.
      launchRun("ones");
      waitRun("ones", cyc);
      checkResult("ones", cyc, N + 5, 1, 438);
      acceptResult("ones");
      @(negedge clk);
      checkOutput("idle_no_start", 64'(bus.busy), 64'd0);

      applyStimulus(0, 0, 0, 100, 100);
      launchRun("tie");
      waitRun("tie", cyc);
      checkResult("tie", cyc, N + 5, 0, 100);
      acceptResult("tie");

      // Ramp buffer: sum of 0..168 = 14196.
      applyStimulus(1, 0, 1, 0, 0);
      launchRun("ramp");
      waitRun("ramp", cyc);
      checkResult("ramp", cyc, N + 5, 1, 14196);
      acceptResult("ramp");
      for (int k = 0; k < N; k++) checkOutput($sformatf("feature_%0d", k), 64'(rec[k]), 64'(k));

      launchRun("rst");
      repeat (81) @(negedge clk);
      checkOutput("rst_feature80", 64'(bus.dl_feature), 64'd80);
      reset_n = 1'b0;
      @(negedge clk);
      checkAllZero("rst_mid_stream");
      checkOutput("rst_state_idle", 64'(dut.state_q == ST_IDLE), 64'd1);
      reset_n = 1'b1;
      applyStimulus(0, 1, 2, 50, 100);
      launchRun("after_rst");
      waitRun("after_rst", cyc);
      checkResult("after_rst", cyc, N + 5, 1, 438);
      acceptResult("after_rst");

      // 3*169=507 vs 169: class 0 held while result_ready stays low and start_req is pending.
      applyStimulus(0, 3, 1, 0, 0);
      launchRun("hold");
      waitRun("hold", cyc);
      checkResult("hold", cyc, N + 5, 0, 507);
      bus.start_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput($sformatf("hold_stable_%0d", i),
                     64'({bus.busy, bus.result_valid, bus.result_class, bus.dl_start, bus.result_score}),
                     64'({1'b1, 1'b1, 1'b0, 1'b0, 32'd507}));
      end
      bus.result_ready = 1'b1;
      @(negedge clk);
      bus.result_ready = 1'b0;
      checkOutput("hold_exit_idle", 64'({bus.busy, bus.result_valid, bus.dl_start}), 64'd0);
      @(negedge clk);
      checkOutput("hold_relaunch", 64'({bus.busy, bus.dl_start}), 64'({1'b1, 1'b1}));
      bus.start_req = 1'b0;
      waitRun("relaunch", cyc);
      checkResult("relaunch", cyc, N + 5, 0, 507);
      acceptResult("relaunch");

`ifdef DENSE_SEQ_TIMEOUT_EN
      hold_done_low = 1'b1;
      launchRun("tmo");
      waitRun("tmo", cyc);
      checkOutput("tmo_latency", 64'(cyc), 64'(N + 1 + TMO));
      checkOutput("tmo_result", 64'({bus.timeout_err, bus.result_valid, bus.result_class, bus.result_score}),
                  64'({1'b1, 1'b1, 1'b0, 32'd0}));
      acceptResult("tmo");
      checkOutput("tmo_sticky", 64'(bus.timeout_err), 64'd1);
      hold_done_low = 1'b0;
`else
      hold_done_low = 1'b1;
      launchRun("nowd");
      repeat (N + 1 + TMO + 20) @(negedge clk);
      checkOutput("nowd_waiting", 64'({bus.busy, bus.result_valid, bus.timeout_err}), 64'({1'b1, 1'b0, 1'b0}));
      reset_n = 1'b0;
      @(negedge clk);
      reset_n       = 1'b1;
      hold_done_low = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dense_sequencer.md
DENSE_SEQUENCER -- requirements
Module: dense_sequencer

Interface
REQ-001 Parameter N_FEATURES, default 169, number of features streamed per inference.
REQ-002 Parameter DONE_TIMEOUT, default 16, max cycles waited for dl_done after the last feature.
REQ-003 clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start_req  input  1  level request for one inference; accepted only in IDLE.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 fb_rd_en  output  1  feature-buffer read strobe.
REQ-008 fb_addr  output  8  feature-buffer read address; data valid on fb_rdata exactly 1 cycle after fb_rd_en.
REQ-009 fb_rdata  input  16 signed  feature-buffer read data.
REQ-010 dl_start  output  1  one-cycle start pulse to the dense layer.
REQ-011 dl_feature  output  16 signed  feature stream to the dense layer.
REQ-012 dl_done  input  1  dense-layer completion level.
REQ-013 dl_score0 / dl_score1  input  32 signed each  dense-layer class scores, valid while dl_done is high.
REQ-014 result_valid  output  1  result available; held until accepted.
REQ-015 result_ready  input  1  consumer accepts the result when high with result_valid.
REQ-016 result_class  output  1  argmax class index.
REQ-017 result_score  output  32 signed  winning score.
REQ-018 timeout_err  output  1  sticky error flag, cleared only by reset.

Function
REQ-019 States: IDLE, LAUNCH, STREAM, WAIT_DONE, RESULT; there are no other reachable states, and any illegal encoding goes to IDLE.
REQ-020 IDLE -> LAUNCH on start_req=1; start_req=0 stays IDLE.
REQ-021 LAUNCH lasts 1 cycle: dl_start=1, fb_rd_en=1, fb_addr=0; next state STREAM.
REQ-022 STREAM: fb_rd_en=1 with fb_addr incrementing 1..N_FEATURES-1, one per cycle; dl_feature is the registered fb_rdata, so feature k appears on dl_feature exactly k+1 cycles after the dl_start cycle.
REQ-023 STREAM holds for N_FEATURES cycles, so the final feature is presented; it then goes to WAIT_DONE, with fb_rd_en=0 and fb_addr returned to 0.
REQ-024 dl_feature is 0 outside the N_FEATURES presentation cycles.
REQ-025 dl_done is ignored in every state except WAIT_DONE, so a stale high level from a previous run has no effect.
REQ-026 WAIT_DONE: on dl_done=1, capture the argmax, then go to RESULT.
REQ-027 Argmax: result_class=1 and result_score=dl_score1 if dl_score1 > dl_score0 (signed compare); otherwise class 0 with dl_score0; a tie selects class 0.
REQ-028 RESULT: result_valid=1 with result_class and result_score stable; on result_ready=1 -> IDLE with result_valid=0 the next cycle.
REQ-029 start_req is not accepted in the cycle RESULT exits; it is accepted earliest on the following cycle.
REQ-030 Sequencer latency from the start_req accept cycle to LAUNCH is 1 cycle.

Reset
REQ-031 reset_n=0 forces IDLE at any time, including mid-STREAM or WAIT_DONE.
REQ-032 During and after reset all outputs are 0, including busy, fb_rd_en, fb_addr, dl_start, dl_feature, result_valid, result_class, result_score and timeout_err.
REQ-033 Release of reset requires no extra cycles; start_req is honoured on the first clock after release.

Configuration
REQ-034 Macro DENSE_SEQ_TIMEOUT_EN defined: a WAIT_DONE cycle counter runs; when DONE_TIMEOUT cycles pass without dl_done, timeout_err is set and the state goes to RESULT with result_valid=1, result_class=0 and result_score=0.
REQ-035 Macro DENSE_SEQ_TIMEOUT_EN undefined: no counter exists, WAIT_DONE waits indefinitely, and timeout_err is tied to 0.

Structure
REQ-036 Shared package dense_pkg holds the state enumeration, N_FEATURES default, feature width 16 and score width 32.
REQ-037 Sub-module dense_argmax holds the combinational signed 2-way compare; everything else is in dense_sequencer.
REQ-038 The bench uses dense_layer as the device downstream of dense_sequencer.

Verification
REQ-039 The bench shall cover the scenarios below.
- Buffer holds all 1s, weights c0=1, c1=2 → scores 219 / 438, result_class=1, result_score=438.
- Scores equal, both 100 → result_class=0, result_score=100.
- Check dl_feature ordering for buffer[k]=k: dense layer feature_count k receives value k for all 169 k.
- Assert reset_n=0 at STREAM feature 80 → next cycle all outputs 0 and state IDLE; a new start_req completes correctly.
- Hold result_ready=0 for 20 cycles in RESULT → result_valid and result fields remain stable; start_req is ignored until release.
- With DENSE_SEQ_TIMEOUT_EN defined and dl_done stuck at 0 → timeout_err=1 exactly DONE_TIMEOUT=16 cycles after WAIT_DONE entry, with result_valid=1, result_class=0 and result_score=0.
